// File: rtl/csa_multiword_seq.sv
// -----------------------------------------------------------------------------
// csa_multiword_seq
//
// Purpose:
//    Multi-cycle adder/subtractor for WIDTH-bit operands. One shared 4-bit
//    carry-select slice processes one nibble per cycle, LSB first. The slice
//    carry-out is registered between cycles. Valid/ready handshakes on both
//    sides let the block sit between an operand source and a result consumer.
//    Subtraction is A + ~B + 1. The result wraps modulo 2**WIDTH, and the
//    final carry is reported on cout.
//
// Parameters:
//    WIDTH      operand/result width (multiple of 4, >= 4)
//
// Ports:
//    clk        in   1      clock, all state updates on rising edge
//    rst        in   1      synchronous active-high reset
//    in_valid   in   1      operand beat valid
//    in_ready   out  1      sequencer can accept an operand beat (IDLE)
//    a, b       in   WIDTH  operands, sampled only on the accept edge
//    cin        in   1      carry-in, ignored when sub=1
//    sub        in   1      0: A+B+cin, 1: A-B
//    out_valid  out  1      result valid (DONE)
//    out_ready  in   1      consumer accepts result
//    sum        out  WIDTH  result, held after handoff
//    cout       out  1      final carry-out (sub: 1 = no borrow)
//    ovf        out  1      signed overflow
//    busy       out  1      high in RUN or DONE
// -----------------------------------------------------------------------------
module csa_multiword_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   generate
      if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
         $error("csa_multiword_seq: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;        // already inverted for subtraction
   logic              r_carry;
   logic [IDXW-1:0]   r_idx;
   logic              r_cout;
   logic              r_ovf;

   logic              w_accept;
   logic              w_run;
   logic              w_last;

   logic [3:0]        w_a_nib;
   logic [3:0]        w_b_nib;
   logic [2:0]        w_lo;
   logic [2:0]        w_hi0;
   logic [2:0]        w_hi1;
   logic [1:0]        w_hi_sel;
   logic [3:0]        w_slice_sum;
   logic              w_slice_cout;
   logic              w_c_msb;

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_run    = (r_state == S_RUN);
   assign w_last   = (r_idx == LAST_IDX);

   // -------------------------------------------------------------------------
   // Operand nibble select for the current slice position
   // -------------------------------------------------------------------------
   always_comb begin
      w_a_nib = 4'h0;
      w_b_nib = 4'h0;
      for (int k = 0; k < NSLICE; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_a_nib = r_a[4*k +: 4];
            w_b_nib = r_b[4*k +: 4];
         end
      end
   end

   // -------------------------------------------------------------------------
   // 4-bit carry-select slice: the low pair of bits ripples from the
   // registered carry while the high pair is precomputed for both possible
   // carries; the low-pair carry-out picks one.
   // -------------------------------------------------------------------------
   assign w_lo  = {1'b0, w_a_nib[1:0]} + {1'b0, w_b_nib[1:0]} + {2'b00, r_carry};
   assign w_hi0 = {1'b0, w_a_nib[3:2]} + {1'b0, w_b_nib[3:2]};
   assign w_hi1 = {1'b0, w_a_nib[3:2]} + {1'b0, w_b_nib[3:2]} + 3'd1;

   always_comb begin
      w_hi_sel     = w_hi0[1:0];
      w_slice_cout = w_hi0[2];
      if (w_lo[2]) begin
         w_hi_sel     = w_hi1[1:0];
         w_slice_cout = w_hi1[2];
      end
   end

   assign w_slice_sum = {w_hi_sel, w_lo[1:0]};

   // Carry into bit 3 of the slice; on the top nibble this is the carry into
   // the result MSB, needed for signed overflow.
   assign w_c_msb = w_a_nib[3] ^ w_b_nib[3] ^ w_slice_sum[3];

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs, decoded purely from the state register so the handshake
   // flags never depend combinationally on the inputs.
   // -------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
         end
         S_RUN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Operand, carry and index registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         // subtraction forces the +1 of the two's complement; cin is ignored
         r_carry <= sub | cin;
         r_idx   <= '0;
      end else if (w_run) begin
         r_carry <= w_slice_cout;
         r_idx   <= r_idx + IDXW'(1);
         if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= w_c_msb ^ w_slice_cout;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Result nibble registers: each nibble loads only while the slice sits on
   // its position, and is cleared when a new operand is accepted.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_sum_nib
         logic [3:0] r_nib;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_nib <= 4'h0;
            end else if (w_accept) begin
               r_nib <= 4'h0;
            end else if (w_run && (r_idx == IDXW'(gi))) begin
               r_nib <= w_slice_sum;
            end
         end

         assign sum[4*gi +: 4] = r_nib;
      end
   endgenerate

   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// -----------------------------------------------------------------------------
// tb_csa_multiword_seq
//
// Purpose:
//    Self-checking bench for csa_multiword_seq. A 16-bit instance runs the
//    directed cases (reset state, latency, wrap/overflow, subtraction,
//    backpressure, mid-run reset, back-to-back throughput). Three further
//    instances (WIDTH 4, 16, 32) then run 1000 random operations each with
//    random input gaps and random out_ready backpressure. Expected results
//    are pushed to a per-instance queue on each accepted operand and popped
//    on each result handoff.
// -----------------------------------------------------------------------------
module tb_csa_multiword_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rnd_done = 0;
   logic dir_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: returns {ovf, cout, sum[31:0]} for a w-bit operation.
   function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin,
                                         input logic sub);
      logic [31:0] mask;
      logic [31:0] bb;
      logic [31:0] s;
      logic [63:0] full;
      logic        am, bm, sm;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      bb   = (sub ? ~b : b) & mask;
      full = {32'h0, a & mask} + {32'h0, bb} + {63'h0, (sub ? 1'b1 : cin)};
      s    = full[31:0] & mask;
      am   = a[w-1];
      bm   = bb[w-1];
      sm   = s[w-1];
      return {((am == bm) && (sm != am)), full[w], s};
   endfunction

   // ---------------------------------------------------------------------------
   // Directed 16-bit instance
   // ---------------------------------------------------------------------------
   logic        d_iv, d_ir, d_ov, d_or, d_cin, d_sub, d_cout, d_ovf, d_busy;
   logic [15:0] d_a, d_b, d_sum;
   logic [33:0] d_q[$];
   int          d_hs[$];
   logic [33:0] d_e;

   csa_multiword_seq #(.WIDTH(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d_iv),
      .in_ready  (d_ir),
      .a         (d_a),
      .b         (d_b),
      .cin       (d_cin),
      .sub       (d_sub),
      .out_valid (d_ov),
      .out_ready (d_or),
      .sum       (d_sum),
      .cout      (d_cout),
      .ovf       (d_ovf),
      .busy      (d_busy)
   );

   always @(negedge clk) begin
      if (!rst) begin
         if (d_iv && d_ir)
            d_q.push_back(model(16, {16'h0, d_a}, {16'h0, d_b}, d_cin, d_sub));
         if (d_ov && d_or) begin
            if (d_q.size() == 0) begin
               chk("d_unexpected_result", 64'd1, 64'd0);
            end else begin
               d_e = d_q.pop_front();
               chk("d_result", {30'h0, d_ovf, d_cout, 16'h0, d_sum}, {30'h0, d_e});
               $display("[TB] w16 result sum=%h cout=%b ovf=%b (exp %h/%b/%b)",
                        d_sum, d_cout, d_ovf, d_e[15:0], d_e[32], d_e[33]);
            end
            d_hs.push_back(cyc);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic d_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
      int n;
      n     = 0;
      d_a   = a;
      d_b   = b;
      d_cin = cin;
      d_sub = sub;
      d_iv  = 1'b1;
      @(negedge clk);
      while (!d_ir && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!d_ir) chk("d_accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      d_iv = 1'b0;
   endtask

   task automatic d_wait_idle();
      int n;
      n = 0;
      while (!d_ir && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!d_ir) chk("d_idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic d_wait_valid();
      int n;
      n = 0;
      while (!d_ov && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!d_ov) chk("d_valid_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      logic [33:0] e4;
      int          n;
      d_iv = 1'b0; d_or = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      chk("rst_in_ready",  d_ir,   64'd1);
      chk("rst_out_valid", d_ov,   64'd0);
      chk("rst_busy",      d_busy, 64'd0);
      chk("rst_sum",       d_sum,  64'd0);
      chk("rst_cout",      d_cout, 64'd0);
      chk("rst_ovf",       d_ovf,  64'd0);

      // 1: basic add with latency check
      d_or = 1'b1;
      d_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         chk("t1_busy", d_busy, 64'd1);
         @(posedge clk);
         #1;
         chk($sformatf("t1_lat_c%0d", k), d_ov, {63'h0, (k == 4)});
      end
      chk("t1_sum", d_sum, 64'h0100);
      d_wait_idle();

      // 2: wrap and signed overflow; 3: subtraction (cin ignored)
      d_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      d_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
      d_op(16'h0005, 16'h0007, 1'b1, 1'b1);
      d_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      d_wait_idle();
      chk("t3_sum",  d_sum,  64'h7FFF);
      chk("t3_cout", d_cout, 64'd1);
      chk("t3_ovf",  d_ovf,  64'd1);

      // 4: backpressure in DONE
      d_or = 1'b0;
      e4   = model(16, 32'h1234, 32'h0F0F, 1'b0, 1'b0);
      d_op(16'h1234, 16'h0F0F, 1'b0, 1'b0);
      d_wait_valid();
      for (int k = 0; k < 5; k++) begin
         d_a  = 16'(k * 16'h1111);
         d_iv = k[0];
         @(posedge clk);
         #1;
         chk("t4_valid",    d_ov,   64'd1);
         chk("t4_in_ready", d_ir,   64'd0);
         chk("t4_sum",      d_sum,  {48'h0, e4[15:0]});
         chk("t4_cout",     d_cout, {63'h0, e4[32]});
         chk("t4_ovf",      d_ovf,  {63'h0, e4[33]});
      end
      d_iv = 1'b0;
      d_or = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_idle_in_ready",  d_ir,  64'd1);
      chk("t4_idle_out_valid", d_ov,  64'd0);
      chk("t4_sum_kept",       d_sum, 64'h2143);

      // 5: reset in the second RUN cycle
      d_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      d_q.delete();
      chk("t5_in_ready",  d_ir,   64'd1);
      chk("t5_out_valid", d_ov,   64'd0);
      chk("t5_sum",       d_sum,  64'd0);
      chk("t5_busy",      d_busy, 64'd0);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         chk("t5_no_result", d_ov, 64'd0);
      end
      d_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      d_wait_idle();
      chk("t5_sum_after", d_sum, 64'h5555);

      // 6: back-to-back throughput, one result every NSLICE+2 cycles
      d_hs.delete();
      d_a  = 16'hABCD;
      d_b  = 16'h1357;
      d_cin = 1'b1;
      d_sub = 1'b0;
      d_iv = 1'b1;
      n = 0;
      while (d_hs.size() < 4 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      d_iv = 1'b0;
      if (d_hs.size() < 4) begin
         chk("t6_timeout", 64'(d_hs.size()), 64'd4);
      end else begin
         for (int i = 0; i < 3; i++)
            chk("t6_period", 64'(d_hs[i+1] - d_hs[i]), 64'd6);
      end
      d_wait_idle();
      repeat (2) @(posedge clk);
      chk("d_queue_drained", 64'(d_q.size()), 64'd0);
      dir_done = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Random scoreboard instances: WIDTH 4, 16, 32
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_rnd
         localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 16 : 32);

         logic         iv, ir, ov, orr, cin, sub, cout, ovf, busy;
         logic [W-1:0] a, b, sum;
         logic [33:0]  q[$];
         logic [33:0]  e;

         csa_multiword_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf),
            .busy      (busy)
         );

         always @(negedge clk) begin
            if (!rst) begin
               if (iv && ir)
                  q.push_back(model(W, 32'(a), 32'(b), cin, sub));
               if (ov && orr) begin
                  if (q.size() == 0) begin
                     chk($sformatf("rnd_w%0d_unexpected", W), 64'd1, 64'd0);
                  end else begin
                     e = q.pop_front();
                     chk($sformatf("rnd_w%0d_result", W),
                         {30'h0, ovf, cout, 32'(sum)}, {30'h0, e});
                     $display("[TB] w%0d result %h exp %h", W,
                              {ovf, cout, 32'(sum)}, e);
                  end
               end
            end
         end

         initial begin
            orr = 1'b0;
            wait (dir_done);
            forever begin
               @(posedge clk);
               #1;
               orr = ($urandom_range(0, 3) != 0);
            end
         end

         initial begin
            int n;
            iv = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            wait (dir_done);
            for (int i = 0; i < 1000; i++) begin
               @(posedge clk);
               #1;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               a   = W'($urandom);
               b   = W'($urandom);
               cin = 1'($urandom_range(0, 1));
               sub = 1'($urandom_range(0, 1));
               iv  = 1'b1;
               n   = 0;
               @(negedge clk);
               while (!ir && n < 100) begin
                  @(negedge clk);
                  n++;
               end
               if (!ir) chk($sformatf("rnd_w%0d_accept_timeout", W), 64'd0, 64'd1);
               @(posedge clk);
               #1;
               iv = 1'b0;
            end
            n = 0;
            while (q.size() != 0 && n < 200) begin
               @(posedge clk);
               n++;
            end
            chk($sformatf("rnd_w%0d_drained", W), 64'(q.size()), 64'd0);
            rnd_done++;
         end
      end
   endgenerate

   initial begin
      wait (rnd_done == 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
